// File: rtl/lsu_mem_port.sv
// Load/store memory port: queues LW/SW requests from execute, runs one memory
// transaction at a time over req/gnt/rvalid and hands load data to writeback.
module lsu_mem_port #(
  parameter int DEPTH = 4,
  parameter int PD_W  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_sdata,
  input  logic [PD_W-1:0] in_pd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [PD_W-1:0] wb_pd,
  output logic [31:0]     wb_data,
  output logic            err_misalign,
  output logic            err_illegal,
  output logic            busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              fifo_st    [DEPTH];
  logic [31:0]       fifo_addr  [DEPTH];
  logic [31:0]       fifo_sdata [DEPTH];
  logic [PD_W-1:0]   fifo_pd    [DEPTH];
  logic [PD_W-1:0]   op_pd;

  logic legal;
  logic accept;
  logic push;
  logic pop;

  // in_ready looks only at the registered count so it never depends on a same-cycle pop
  assign in_ready = (count != CNT_W'(DEPTH));
  assign legal    = (in_opcode == OP_LW) || (in_opcode == OP_SW);
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = (state == IDLE) && (count != '0);
  assign busy     = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_st[wr_ptr]    <= (in_opcode == OP_SW);
      fifo_addr[wr_ptr]  <= in_addr;
      fifo_sdata[wr_ptr] <= in_sdata;
      fifo_pd[wr_ptr]    <= in_pd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_pd        <= '0;
      wb_data      <= '0;
      err_misalign <= 1'b0;
      err_illegal  <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      err_illegal  <= accept && !legal;
      case (state)
        IDLE: begin
          if (pop) begin
            if (fifo_addr[rd_ptr][1:0] != 2'b00) begin
              err_misalign <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= fifo_st[rd_ptr];
              mem_addr  <= fifo_addr[rd_ptr];
              mem_wdata <= fifo_st[rd_ptr] ? fifo_sdata[rd_ptr] : 32'h0;
              op_pd     <= fifo_pd[rd_ptr];
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= mem_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            // loads targeting x0 complete without a writeback
            if (op_pd != '0) begin
              state    <= WB;
              wb_valid <= 1'b1;
              wb_pd    <= op_pd;
              wb_data  <= mem_rdata;
            end else begin
              state <= IDLE;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a memory responder with programmable
// gnt/rvalid delays plus directed latency, back-pressure, error and reset cases.
module tb_lsu_mem_port;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_RR = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [31:0] in_addr;
  logic [31:0] in_sdata;
  logic [5:0]  in_pd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  wb_pd;
  logic [31:0] wb_data;
  logic        err_misalign;
  logic        err_illegal;
  logic        busy;

  lsu_mem_port #(.DEPTH(4), .PD_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_pd(in_pd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pd(wb_pd), .wb_data(wb_data),
    .err_misalign(err_misalign), .err_illegal(err_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cyc = 0;
  int wb_hs = 0;
  int mis_cnt = 0;
  int ill_cnt = 0;
  int gnt_delay = 0;
  int rv_delay = 1;

  logic [64:0] mem_q[$];
  logic [37:0] wb_q[$];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h104) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [5:0] pd, input bit exp_wb);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_addr   = a;
    in_sdata  = d;
    in_pd     = pd;
    if ((op == OP_LW || op == OP_SW) && a[1:0] == 2'b00) begin
      mem_q.push_back({op == OP_SW, a, (op == OP_SW) ? d : 32'h0});
      if (op == OP_LW && pd != 6'd0 && exp_wb) wb_q.push_back({pd, mem_fn(a)});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Memory responder: gnt after gnt_delay waiting cycles, rvalid rv_delay cycles after gnt
  int          req_age = 0;
  int          rv_cnt = 0;
  bit          rv_pend = 0;
  logic [31:0] rv_addr = '0;
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      if (rv_pend) begin
        rv_cnt--;
        if (rv_cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_fn(rv_addr);
          rv_pend = 0;
        end
      end
      if (mem_req) begin
        if (req_age >= gnt_delay) begin
          mem_gnt = 1'b1;
          req_age = 0;
          if (!mem_we) begin
            rv_pend = 1;
            rv_cnt = rv_delay;
            rv_addr = mem_addr;
          end
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  // Monitor: scoreboard pops, hold-stability and event counters
  bit          ph_req = 0;
  bit          ph_wb = 0;
  logic [31:0] p_addr = '0;
  logic [37:0] p_wb = '0;
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        ph_req = 0;
        ph_wb = 0;
      end else begin
        if (ph_req) begin
          chk("req_hold", mem_req, 1'b1);
          chk("req_addr_stable", mem_addr, p_addr);
        end
        if (mem_req) begin
          req_cyc++;
          if (mem_gnt) begin
            if (mem_q.size() == 0) chk("mem_unexpected", {mem_we, mem_addr, mem_wdata}, 65'h0);
            else chk("mem_op", {mem_we, mem_addr, mem_wdata}, mem_q.pop_front());
          end
        end
        ph_req = mem_req && !mem_gnt;
        p_addr = mem_addr;
        if (ph_wb) begin
          chk("wb_hold", wb_valid, 1'b1);
          chk("wb_stable", {wb_pd, wb_data}, p_wb);
        end
        if (wb_valid && wb_ready) begin
          wb_hs++;
          if (wb_q.size() == 0) chk("wb_unexpected", {wb_pd, wb_data}, 38'h0);
          else chk("wb_result", {wb_pd, wb_data}, wb_q.pop_front());
        end
        ph_wb = wb_valid && !wb_ready;
        p_wb = {wb_pd, wb_data};
        if (err_misalign) mis_cnt++;
        if (err_illegal) ill_cnt++;
      end
    end
  end

  initial begin
    int r0, w0, m0, i0, n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_opcode = '0;
    in_addr = '0;
    in_sdata = '0;
    in_pd = '0;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errs", {err_misalign, err_illegal}, 2'b00);

    // store, immediate grant
    r0 = req_cyc; w0 = wb_hs;
    send(OP_SW, 32'h100, 32'hDEADBEEF, 6'd0, 1'b0);
    chk("sw_busy_q", busy, 1'b1);
    step();
    chk("sw_req", {mem_req, mem_we}, 2'b11);
    step();
    chk("sw_req_drop", mem_req, 1'b0);
    chk("sw_busy_drop", busy, 1'b0);
    step();
    chk("sw_req_cycles", req_cyc - r0, 1);
    chk("sw_no_wb", wb_hs - w0, 0);

    // load with delayed grant and rvalid
    gnt_delay = 3; rv_delay = 2;
    r0 = req_cyc; w0 = wb_hs;
    send(OP_LW, 32'h104, 32'h0, 6'd5, 1'b1);
    wait_idle("lw_idle");
    step();
    chk("lw_req_cycles", req_cyc - r0, 4);
    chk("lw_wb_count", wb_hs - w0, 1);

    // zero-wait load latency
    gnt_delay = 0; rv_delay = 1;
    send(OP_LW, 32'h200, 32'h0, 6'd7, 1'b1);
    chk("lat_idle_q", mem_req, 1'b0);
    step();
    chk("lat_req", mem_req, 1'b1);
    step();
    chk("lat_wait", {mem_req, wb_valid}, 2'b00);
    step();
    chk("lat_wb", {wb_valid, wb_pd}, {1'b1, 6'd7});
    wait_idle("lat_done");

    // writeback back-pressure while the FIFO fills
    wb_ready = 1'b0;
    w0 = wb_hs;
    send(OP_LW, 32'h300, 32'h0, 6'd9, 1'b1);
    n = 0;
    while (!wb_valid && n < 50) begin
      step();
      n++;
    end
    chk("bp_wb_valid", wb_valid, 1'b1);
    for (int i = 0; i < 4; i++) send(OP_LW, 32'h310 + 32'(i * 4), 32'h0, 6'(10 + i), 1'b1);
    chk("bp_full", in_ready, 1'b0);
    step();
    chk("bp_full_hold", in_ready, 1'b0);
    chk("bp_wb_hold", {wb_valid, wb_pd}, {1'b1, 6'd9});
    wb_ready = 1'b1;
    wait_idle("bp_drain");
    step();
    chk("bp_wb_count", wb_hs - w0, 5);

    // x0 load then misaligned load
    r0 = req_cyc; w0 = wb_hs; m0 = mis_cnt;
    send(OP_LW, 32'h400, 32'h0, 6'd0, 1'b1);
    send(OP_LW, 32'h102, 32'h0, 6'd3, 1'b1);
    wait_idle("mis_idle");
    chk("mis_pulse", err_misalign, 1'b1);
    step();
    chk("mis_pulse_end", err_misalign, 1'b0);
    chk("mis_req_cycles", req_cyc - r0, 1);
    chk("mis_no_wb", wb_hs - w0, 0);
    chk("mis_count", mis_cnt - m0, 1);

    // illegal opcode
    r0 = req_cyc; i0 = ill_cnt;
    send(OP_RR, 32'h600, 32'h1, 6'd2, 1'b1);
    chk("ill_pulse", err_illegal, 1'b1);
    chk("ill_not_pushed", busy, 1'b0);
    step();
    chk("ill_pulse_end", {err_illegal, mem_req}, 2'b00);
    step();
    chk("ill_count", ill_cnt - i0, 1);
    chk("ill_no_req", req_cyc - r0, 0);

    // reset during WAIT; the late rvalid must be ignored
    gnt_delay = 0; rv_delay = 4;
    w0 = wb_hs;
    send(OP_LW, 32'h500, 32'h0, 6'd4, 1'b0);
    step();
    step();
    chk("rstw_in_wait", {mem_req, busy}, 2'b01);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rstw_no_wb", wb_hs - w0, 0);
    chk("rstw_wb_valid", wb_valid, 1'b0);
    chk("rstw_in_ready", in_ready, 1'b1);
    chk("rstw_busy", busy, 1'b0);

    // mixed traffic
    gnt_delay = 1; rv_delay = 2;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = $urandom() & 32'h0000FFFC;
      if ($urandom_range(0, 1) == 1)
        send(OP_SW, a, $urandom(), 6'd0, 1'b0);
      else
        send(OP_LW, a, 32'h0, 6'($urandom_range(1, 63)), 1'b1);
    end
    wait_idle("mix_idle");
    step();
    chk("mem_q_empty", mem_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-side consumer of the ALU effective-address result for LW/SW.
- Accepts address, store data and physical destination (pd) from the execute stage into an in-order request FIFO.
- Drives a variable-latency data-memory req/gnt/rvalid interface, then returns load data with pd to the writeback/commit stage over a valid/ready handshake.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- PD_W, 6, physical destination tag width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  execute stage presents a request
- in_ready  out  1  request accepted when in_valid && in_ready
- in_opcode  in  7  7'b0000011 = LW, 7'b0100011 = SW
- in_addr  in  32  effective address (ALU result)
- in_sdata  in  32  store data (rs2 value)
- in_pd  in  PD_W  load destination tag
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address
- mem_wdata  out  32  store data
- mem_gnt  in  1  request taken this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data
- wb_valid  out  1  load result valid
- wb_ready  in  1  writeback consumes the result
- wb_pd  out  PD_W  destination tag
- wb_data  out  32  load data
- err_misalign  out  1  one-cycle pulse: addr[1:0] != 0
- err_illegal  out  1  one-cycle pulse: unsupported opcode accepted
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:

Reset (rst_n low at a rising edge):
- FIFO empty; FSM to IDLE.
- All outputs 0, except in_ready = 1 from the first cycle after reset.
- Reset mid-transaction abandons the operation.
- Any mem_gnt/mem_rvalid arriving after reset is ignored; no wb is produced for it.

FIFO:
- in_ready = !full; depends only on the registered count, never on this cycle's pop.
- Push on in_valid && in_ready with a legal opcode.
- Illegal opcode: accepted (handshake completes), not pushed, err_illegal pulses the next cycle.
- Pointers wrap modulo DEPTH; count is 0..DEPTH.
- Push and pop in the same cycle leave the count unchanged.

FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - FIFO empty: stay.
  - Otherwise pop the head into operation registers.
  - If head addr[1:0] != 0: no memory access, err_misalign pulses the next cycle, stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1; mem_we/mem_addr/mem_wdata come from the operation registers and are stable until gnt.
  - mem_wdata = 0 for loads.
  - Store with mem_gnt: go to IDLE (store complete, no wb).
  - Load with mem_gnt: go to WAIT.
  - No gnt: hold.
- WAIT:
  - mem_req = 0.
  - mem_rvalid arrives no earlier than the cycle after gnt.
  - On mem_rvalid, capture mem_rdata.
  - pd != 0: go to WB. pd == 0 (x0): discard the data and go to IDLE.
- WB:
  - wb_valid = 1; wb_pd/wb_data stable until wb_ready.
  - On wb_ready, go to IDLE.

Ordering and latency:
- Strictly in order; one memory transaction outstanding.
- Request accepted at edge k: pop at edge k+1, mem_req high during cycle k+1..k+2.
- Load with zero-wait gnt and rvalid the following cycle: wb_valid high 2 cycles after first mem_req.
- No new pop until the FSM returns to IDLE; the pop can occur on the same edge the FSM enters IDLE only for the next cycle (IDLE lasts ≥1 cycle).

Outputs:
- busy = (count != 0) || (state != IDLE).

Test Plan:
- SW addr=0x100, sdata=0xDEADBEEF, gnt on first REQ cycle -> exactly one mem_req cycle with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; no wb_valid; busy drops 1 cycle later.
- LW addr=0x104, pd=5, gnt delayed 3 cycles, rvalid 2 cycles after gnt with 0x12345678 -> mem_req held 4 cycles with stable address; wb_valid with wb_pd=5, wb_data=0x12345678.
- wb_ready held low 5 cycles -> wb_valid/wb_pd/wb_data stable; meanwhile push DEPTH requests -> in_ready drops at count=4; releasing wb_ready drains them in order.
- LW pd=0 and LW addr=0x102 -> first performs a memory read with no wb; second produces one err_misalign pulse and no mem_req.
- in_opcode=7'b0110011 -> accepted, err_illegal pulse, FIFO count unchanged, no memory activity.
- Reset asserted during WAIT, then mem_rvalid=1 -> no wb_valid; FIFO empty; in_ready=1; busy=0.
